// File: rtl/dffram_bist.sv
// dffram_bist: self-test engine for a single-port DFF RAM.
// Runs an address-in-data test or a March C- test and stops on the first
// mismatch. The first failing address, the data read and the expected data
// are kept until the next start.
module dffram_bist #(
    parameter int WSIZE  = 4,
    parameter int AWIDTH = 8,
    parameter int RD_LAT = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [AWIDTH-1:0]   fail_addr,
    output logic [WSIZE*8-1:0]  fail_data,
    output logic [WSIZE*8-1:0]  fail_exp,
    output logic                EN0,
    output logic [WSIZE-1:0]    WE0,
    output logic [AWIDTH-1:0]   A0,
    output logic [WSIZE*8-1:0]  Di0,
    input  logic [WSIZE*8-1:0]  Do0
);
    localparam int DW   = WSIZE * 8;
    localparam int REPS = (DW + AWIDTH - 1) / AWIDTH;
    localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);
    localparam logic [AWIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [2:0] {IDLE, WR, RD, WAIT, DONE} state_t;

    state_t            st_q, st_d;
    logic              march_q, march_d;     // 1: March C-, 0: address-in-data
    logic [2:0]        elem_q, elem_d;       // pass (mode 0) or march element
    logic              sub_q, sub_d;         // op index within a march element
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic [1:0]        wcnt_q, wcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [AWIDTH-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0]     fail_data_q, fail_data_d;
    logic [DW-1:0]     fail_exp_q, fail_exp_d;
    logic              en_q, en_d;
    logic [WSIZE-1:0]  we_q, we_d;
    logic [DW-1:0]     di_q, di_d;
    logic [DW-1:0]     exp_q, exp_d;         // expected word of the read in flight

    // Position of the op following the current one
    logic [2:0]        nxt_elem;
    logic              nxt_sub;
    logic [AWIDTH-1:0] nxt_addr;
    logic              nxt_end;

    // Op to be presented on the next edge
    logic              launch, finish, ok;
    logic              op_march, op_wr;
    logic [2:0]        op_elem;
    logic              op_sub;
    logic [AWIDTH-1:0] op_addr;
    logic [DW-1:0]     op_val;

    // Address replicated from the LSB up, truncated to the word width
    function automatic logic [DW-1:0] addr_pattern(input logic [AWIDTH-1:0] a);
        logic [REPS*AWIDTH-1:0] r;
        r = {REPS{a}};
        return r[DW-1:0];
    endfunction

    function automatic logic is_desc(input logic m, input logic [2:0] e);
        return m && (e >= 3'd3);
    endfunction

    // March elements 1..4 are read-then-write; all others are a single op
    function automatic logic two_ops(input logic m, input logic [2:0] e);
        return m && (e >= 3'd1) && (e <= 3'd4);
    endfunction

    function automatic logic last_elem(input logic m, input logic [2:0] e);
        return m ? (e == 3'd5) : (e == 3'd3);
    endfunction

    function automatic logic is_write(input logic m, input logic [2:0] e, input logic s);
        logic w;
        if (!m)                         w = ~e[0];
        else if (e == 3'd0)             w = 1'b1;
        else if (e == 3'd5)             w = 1'b0;
        else                            w = s;
        return w;
    endfunction

    function automatic logic [DW-1:0] op_data(input logic m, input logic [2:0] e,
                                              input logic s, input logic [AWIDTH-1:0] a);
        logic [DW-1:0] d;
        if (!m)                              d = e[1] ? ~addr_pattern(a) : addr_pattern(a);
        else if (e == 3'd0 || e == 3'd5)     d = '0;
        else if (e == 3'd1 || e == 3'd3)     d = s ? '1 : '0;
        else                                 d = s ? '0 : '1;
        return d;
    endfunction

    // Step the op sequencer: next op in the element, next address, or next element
    always_comb begin
        nxt_elem = elem_q;
        nxt_sub  = 1'b0;
        nxt_addr = addr_q;
        nxt_end  = 1'b0;
        if (two_ops(march_q, elem_q) && !sub_q) begin
            nxt_sub = 1'b1;
        end else if (is_desc(march_q, elem_q) ? (addr_q == '0) : (addr_q == ADDR_MAX)) begin
            if (last_elem(march_q, elem_q)) begin
                nxt_end = 1'b1;
            end else begin
                nxt_elem = elem_q + 3'd1;
                nxt_addr = is_desc(march_q, elem_q + 3'd1) ? ADDR_MAX : '0;
            end
        end else begin
            nxt_addr = is_desc(march_q, elem_q) ? addr_q - AWIDTH'(1) : addr_q + AWIDTH'(1);
        end
    end

    // FSM next-state and RAM/result output decoding
    always_comb begin
        st_d        = st_q;
        march_d     = march_q;
        elem_d      = elem_q;
        sub_d       = sub_q;
        addr_d      = addr_q;
        wcnt_d      = wcnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_exp_d  = fail_exp_q;
        en_d        = en_q;
        we_d        = we_q;
        di_d        = di_q;
        exp_d       = exp_q;
        launch      = 1'b0;
        finish      = 1'b0;
        ok          = 1'b1;
        op_march    = march_q;
        op_elem     = nxt_elem;
        op_sub      = nxt_sub;
        op_addr     = nxt_addr;

        case (st_q)
            IDLE: begin
                if (start) begin
                    march_d     = (mode == 2'd1);
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_exp_d  = '0;
                    op_march    = (mode == 2'd1);
                    op_elem     = 3'd0;
                    op_sub      = 1'b0;
                    op_addr     = '0;
                    launch      = 1'b1;
                end
            end
            WR: begin
                if (nxt_end) finish = 1'b1;
                else         launch = 1'b1;
            end
            RD: begin
                en_d   = 1'b0;
                wcnt_d = 2'd0;
                st_d   = WAIT;
            end
            WAIT: begin
                if (wcnt_q == LAT_LAST) begin
                    if (Do0 != exp_q) begin
                        finish      = 1'b1;
                        ok          = 1'b0;
                        fail_addr_d = addr_q;
                        fail_data_d = Do0;
                        fail_exp_d  = exp_q;
                    end else if (nxt_end) begin
                        finish = 1'b1;
                    end else begin
                        launch = 1'b1;
                    end
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            DONE: st_d = IDLE;
            default: st_d = IDLE;
        endcase

        op_wr  = is_write(op_march, op_elem, op_sub);
        op_val = op_data(op_march, op_elem, op_sub, op_addr);

        if (launch) begin
            elem_d = op_elem;
            sub_d  = op_sub;
            addr_d = op_addr;
            en_d   = 1'b1;
            we_d   = op_wr ? '1 : '0;
            di_d   = op_wr ? op_val : '0;
            exp_d  = op_val;
            st_d   = op_wr ? WR : RD;
        end

        if (finish) begin
            st_d   = DONE;
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = ok;
            en_d   = 1'b0;
            we_d   = '0;
        end
    end

    // State and registered outputs, cleared asynchronously by RST_N
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            st_q        <= IDLE;
            march_q     <= 1'b0;
            elem_q      <= 3'd0;
            sub_q       <= 1'b0;
            addr_q      <= '0;
            wcnt_q      <= 2'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
            en_q        <= 1'b0;
            we_q        <= '0;
            di_q        <= '0;
            exp_q       <= '0;
        end else begin
            st_q        <= st_d;
            march_q     <= march_d;
            elem_q      <= elem_d;
            sub_q       <= sub_d;
            addr_q      <= addr_d;
            wcnt_q      <= wcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
            en_q        <= en_d;
            we_q        <= we_d;
            di_q        <= di_d;
            exp_q       <= exp_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
    assign fail_exp  = fail_exp_q;
    assign EN0       = en_q;
    assign WE0       = we_q;
    assign A0        = addr_q;
    assign Di0       = di_q;

endmodule
